jk_bank_driver: RTL
===================

# jk_bank_driver

Command-side controller for a bank of WIDTH synchronous JK flip-flops (posedge clk, sync reset, J/K truth table: 00 hold, 01 clear, 10 set, 11 toggle). It accepts a target word over a valid/ready handshake and generates one-cycle J/K command pulses that move the bank to that word. It then checks the bank's fed-back outputs and retries a bounded number of times before flagging an error. It sits between sequencing logic and any JK register bank in the design, so no other block drives J/K directly.

## Interface
- WIDTH, 8: number of JK flops in the driven bank.
- MAX_RETRY, 2: extra drive attempts after the first; legal range 0..14.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- tgt_valid  in  1  target word offered.
- tgt_ready  out  1  block can accept a target; equals (state==IDLE) & ~rst.
- tgt_data  in  WIDTH  requested bank value.
- mode  in  1  encoding select, sampled with the target: 0 = set/clear (10/01), 1 = toggle (11).
- q_fb  in  WIDTH  current outputs of the driven JK bank.
- j  out  WIDTH  registered J commands to the bank.
- k  out  WIDTH  registered K commands to the bank.
- done  out  1  one-cycle pulse when the operation ends.
- err  out  1  valid only with done; 1 means the bank never matched the target.
- attempts  out  4  number of drive pulses issued for the last operation; held until the next done.

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE: j=k=0, tgt_ready=1. When tgt_valid&tgt_ready, capture tgt_data and mode into tgt_r/mode_r, clear the retry counter, compute commands from q_fb and go to DRIVE.
- Command computation for each bit i, with d = q_fb[i]^tgt[i]:
  - d=0: j=0, k=0.
  - d=1 in mode 0: j=tgt[i], k=~tgt[i].
  - d=1 in mode 1: j=1, k=1.
- DRIVE: lasts exactly one cycle with the computed j/k on the outputs. Then go to CHECK with j=k=0.
- CHECK: lasts one cycle with j=k=0. At the end of the cycle, compare q_fb with tgt_r:
  - Equal: done=1, err=0, go to IDLE.
  - Unequal and retries<MAX_RETRY: increment retries, recompute commands from the current q_fb, go to DRIVE.
  - Unequal and retries==MAX_RETRY: done=1, err=1, go to IDLE.
- A target equal to q_fb still runs one DRIVE cycle with j=k=0, then CHECK; result is done with attempts=1.
- attempts = retries+1, latched when done is asserted.
- j and k are never both 1 in mode 0. j/k are non-zero only in DRIVE.
- tgt_valid is ignored outside IDLE; the target is held off by tgt_ready=0.
- Reset values: state IDLE, j=0, k=0, done=0, err=0, attempts=0, tgt_r=0, mode_r=0.
- rst during DRIVE or CHECK aborts the operation. The next cycle shows j=k=0 and done=0, and no done pulse is issued for the aborted target.

## Timing
- Edge E0 accepts the target. Cycle 1 is DRIVE, and the bank updates at E1.
- Cycle 2 is CHECK, and the compare happens at E2. done is high in cycle 3, and tgt_ready is high again in cycle 3.
- Successful single attempt: 3 cycles from acceptance to done. Each retry adds 2 cycles. Worst case is 3+2*MAX_RETRY cycles.
- Back-to-back: a new target may be accepted in the same cycle that done is high.
- The bank must register J/K on the same clk edge; q_fb is treated as stable one cycle after DRIVE.

## Test plan
- Mode 0, bank=0x00, target 0xA5 -> j=0xA5, k=0x00 for exactly one cycle; done 3 cycles after acceptance; err=0, attempts=1, bank=0xA5.
- Mode 1, bank=0xA5, target 0x5A -> j=k=0xFF for one cycle; done with err=0, attempts=1, bank=0x5A.
- Mode 0, bank=0x3C, target 0x3C -> j=k=0x00 throughout; done at cycle 3, err=0, attempts=1.
- Fault model with bit 0 stuck at 0, target 0x01, MAX_RETRY=2 -> three DRIVE pulses with j=0x01 at cycles 1, 3, 5; done with err=1 at cycle 7; attempts=3.
- Assert rst for one cycle during CHECK -> next cycle j=k=0, tgt_ready=1, no done pulse. A subsequent target 0xFF completes normally with attempts=1.
- Hold tgt_valid high with a second target while busy -> second target accepted only in the done cycle; j/k for the second target follow immediately in the next cycle.

Source files
------------

// File: rtl/jk_bank_driver_if.sv
// ============================================================================
// Module      : jk_bank_driver_if
// Description : Target handshake, status and J/K command bundle for jk_bank_driver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface jk_bank_driver_if #(
    parameter int WIDTH = 8
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic             mode;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             done;
    logic             err;
    logic [3:0]       attempts;

    // master: sequencer plus the driven bank; slave: the driver itself
    modport master (
        output tgt_valid, tgt_data, mode, q_fb,
        input  tgt_ready, j, k, done, err, attempts
    );

    modport slave (
        input  tgt_valid, tgt_data, mode, q_fb,
        output tgt_ready, j, k, done, err, attempts
    );
endinterface

`default_nettype wire

// File: rtl/jk_bank_driver.sv
// ============================================================================
// Module      : jk_bank_driver
// Description : Drives a JK flop bank to a target word, verifies, retries.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jk_bank_driver #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2
) (
    input  wire                 clk,
    input  wire                 rst,
    jk_bank_driver_if.slave     bus
);
    localparam logic [3:0] MAX_RETRY_W = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_r;
    logic             mode_r;
    logic [3:0]       retries, retries_nxt;
    logic [3:0]       attempts_r;
    logic [WIDTH-1:0] j_r, k_r, j_nxt, k_nxt;
    logic             done_r, err_r, done_nxt, err_nxt;
    logic             capture;

    logic [WIDTH-1:0] src_tgt, diff, j_cmd, k_cmd;
    logic             src_mode;

    // In IDLE the commands come from the word being offered; on a retry
    // they come from the captured target against the current bank state.
    always_comb begin
        src_tgt  = (state == IDLE) ? bus.tgt_data : tgt_r;
        src_mode = (state == IDLE) ? bus.mode     : mode_r;
        diff     = bus.q_fb ^ src_tgt;
        j_cmd    = diff & (src_mode ? {WIDTH{1'b1}} : src_tgt);
        k_cmd    = diff & (src_mode ? {WIDTH{1'b1}} : ~src_tgt);
    end

    always_comb begin
        state_nxt   = state;
        retries_nxt = retries;
        j_nxt       = '0;
        k_nxt       = '0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.tgt_valid) begin
                    capture     = 1'b1;
                    retries_nxt = 4'd0;
                    j_nxt       = j_cmd;
                    k_nxt       = k_cmd;
                    state_nxt   = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                if (bus.q_fb == tgt_r) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (retries < MAX_RETRY_W) begin
                    retries_nxt = retries + 4'd1;
                    j_nxt       = j_cmd;
                    k_nxt       = k_cmd;
                    state_nxt   = DRIVE;
                end else begin
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tgt_r      <= '0;
            mode_r     <= 1'b0;
            retries    <= 4'd0;
            attempts_r <= 4'd0;
            j_r        <= '0;
            k_r        <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state   <= state_nxt;
            retries <= retries_nxt;
            j_r     <= j_nxt;
            k_r     <= k_nxt;
            done_r  <= done_nxt;
            err_r   <= err_nxt;
            if (capture) begin
                tgt_r  <= bus.tgt_data;
                mode_r <= bus.mode;
            end
            if (done_nxt) begin
                attempts_r <= retries + 4'd1;
            end
        end
    end

    assign bus.tgt_ready = (state == IDLE) & ~rst;
    assign bus.j         = j_r;
    assign bus.k         = k_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.attempts  = attempts_r;

endmodule

`default_nettype wire
